weigh_station_ctrl: RTL and testbench
=====================================

// Module: weigh_station_ctrl
// PURPOSE
//   Sequencer for the vehicle classifier (4-bit weight p3..p0, 2-bit axle e1e0 -> c1/c2/c3/E).
//   Waits for a vehicle, waits until the weight/axle sensor readings are stable, then drives them to the classifier.
//   Registers and validates the classifier result, hands it to the operator side with a valid/ack handshake, and drives the exit gate.
//   Keeps saturating per-category and error tallies.
// PARAMETERS
//   STABLE_CYC  4  consecutive matching cycles required on the sensor readings, and on vehicle exit (>=1)
//   CNT_W       8  width of each tally counter
// PORTS
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   veh_present  in   1      vehicle-on-scale sensor (already synchronised)
//   peso_in      in   4      weight sensor reading
//   eixo_in      in   2      axle-count sensor reading
//   cls_p        out  4      to classifier {p3,p2,p1,p0}
//   cls_e        out  2      to classifier {e1,e0}
//   cls_c1/c2/c3 in   1 each classifier category outputs (combinational from cls_p/cls_e)
//   cls_E        in   1      classifier error output
//   res_valid    out  1      result available
//   res_cat      out  2      0=none, 1/2/3 = category c1/c2/c3
//   res_err      out  1      result is an error
//   res_ack      in   1      result consumed
//   gate_open    out  1      exit gate command
//   busy         out  1      FSM is not in IDLE
//   clr_cnt      in   1      synchronous clear of all tallies
//   cnt_c1/c2/c3 out  CNT_W  category tallies
//   cnt_err      out  CNT_W  error tally
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; every output and internal register is 0.
//   FSM states: IDLE, SETTLE, SAMPLE, REPORT, EXIT.
//   - IDLE
//     - If veh_present=1: capture peso_in/eixo_in into the sample registers, clear stab_cnt, go to SETTLE.
//   - SETTLE
//     - If veh_present=0: go to IDLE; nothing is counted.
//     - Else if the inputs differ from the sample registers: recapture and set stab_cnt=0.
//     - Else if stab_cnt==STABLE_CYC-1: go to SAMPLE.
//     - Else: increment stab_cnt.
//   - SAMPLE (exactly 1 cycle)
//     - Classifier outputs are registered at the end of the cycle.
//     - err = cls_E | (number of c1..c3 high != 1).
//     - res_cat = 0 if err, otherwise the index of the high category.
//     - The matching tally (or cnt_err) increments. Go to REPORT.
//   - REPORT
//     - res_valid=1; res_cat and res_err are held stable until accepted.
//     - Acceptance is res_valid&res_ack in the same cycle.
//     - Next cycle: res_valid=0; gate_open=1 only if !err; go to EXIT.
//     - veh_present falling during REPORT is ignored.
//   - EXIT
//     - Count consecutive cycles with veh_present=0; a cycle with 1 restarts the count.
//     - At STABLE_CYC cycles: gate_open=0 and go to IDLE.
//   cls_p/cls_e always equal the sample registers (registered outputs; they do not follow the raw inputs).
//   Latency: the first stable sample cycle -> res_valid = STABLE_CYC+2 cycles.
//   Tallies saturate at 2^CNT_W-1.
//   clr_cnt has priority over a same-cycle increment (that increment is lost).
//   busy = (state != IDLE).
//   Reset mid-operation returns to IDLE immediately, closes the gate, and clears the tallies.
// TESTING
//   1. Stub classifier c2=1; veh=1, peso=9, eixo=2 held -> res_valid after STABLE_CYC+2 cycles, res_cat=2, err=0; ack -> gate_open=1, cnt_c2=1.
//   2. peso toggles 9->10 at cycle 2 of SETTLE -> the stability count restarts; cls_p settles to 10 and is presented after 4 more stable cycles.
//   3. Stub cls_E=1 (also c1=c3=1 with E=0) -> res_err=1, res_cat=0, cnt_err increments, gate stays 0 after ack.
//   4. veh=0 during SETTLE -> IDLE, no tally change; veh bounces 0-1-0 in EXIT -> gate closes only after 4 consecutive zeros.
//   5. Preset cnt_c1=255 -> another c1 vehicle leaves it at 255; clr_cnt asserted on the SAMPLE cycle -> cnt_c1=0.
//   6. rst_n=0 while in REPORT -> res_valid=0, gate_open=0, busy=0, tallies 0 asynchronously.

Source files
------------

// File: rtl/weigh_station_ctrl.sv
// Vehicle weigh-station sequencer: settles sensor readings, samples the classifier,
// reports the result over a valid/ack handshake, drives the exit gate and keeps tallies.
module weigh_station_ctrl #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             veh_present,
    input  logic [3:0]       peso_in,
    input  logic [1:0]       eixo_in,
    output logic [3:0]       cls_p,
    output logic [1:0]       cls_e,
    input  logic             cls_c1,
    input  logic             cls_c2,
    input  logic             cls_c3,
    input  logic             cls_E,
    output logic             res_valid,
    output logic [1:0]       res_cat,
    output logic             res_err,
    input  logic             res_ack,
    output logic             gate_open,
    output logic             busy,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_c1,
    output logic [CNT_W-1:0] cnt_c2,
    output logic [CNT_W-1:0] cnt_c3,
    output logic [CNT_W-1:0] cnt_err
);

    localparam int unsigned STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, REPORT, EXIT} state_t;

    state_t            state, state_nxt;
    logic [STAB_W-1:0] stab_cnt, stab_cnt_nxt;
    logic [3:0]        cls_p_nxt;
    logic [1:0]        cls_e_nxt;
    logic              res_valid_nxt, res_err_nxt, gate_open_nxt;
    logic [1:0]        res_cat_nxt;
    logic [CNT_W-1:0]  cnt_c1_nxt, cnt_c2_nxt, cnt_c3_nxt, cnt_err_nxt;
    logic [1:0]        hot_cnt;
    logic              dec_err;
    logic [1:0]        dec_cat;

    // Classifier result decode: exactly one category must be high and no error flagged.
    always_comb begin
        hot_cnt = 2'(cls_c1) + 2'(cls_c2) + 2'(cls_c3);
        dec_err = cls_E | (hot_cnt != 2'd1);
        if (dec_err)     dec_cat = 2'd0;
        else if (cls_c1) dec_cat = 2'd1;
        else if (cls_c2) dec_cat = 2'd2;
        else             dec_cat = 2'd3;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        stab_cnt_nxt  = stab_cnt;
        cls_p_nxt     = cls_p;
        cls_e_nxt     = cls_e;
        res_valid_nxt = res_valid;
        res_cat_nxt   = res_cat;
        res_err_nxt   = res_err;
        gate_open_nxt = gate_open;
        cnt_c1_nxt    = cnt_c1;
        cnt_c2_nxt    = cnt_c2;
        cnt_c3_nxt    = cnt_c3;
        cnt_err_nxt   = cnt_err;

        case (state)
            IDLE: begin
                if (veh_present) begin
                    cls_p_nxt    = peso_in;
                    cls_e_nxt    = eixo_in;
                    stab_cnt_nxt = '0;
                    state_nxt    = SETTLE;
                end
            end
            SETTLE: begin
                if (!veh_present) begin
                    state_nxt = IDLE;
                end else if ((peso_in != cls_p) || (eixo_in != cls_e)) begin
                    cls_p_nxt    = peso_in;
                    cls_e_nxt    = eixo_in;
                    stab_cnt_nxt = '0;
                end else if (stab_cnt == STAB_MAX) begin
                    state_nxt = SAMPLE;
                end else begin
                    stab_cnt_nxt = stab_cnt + STAB_W'(1);
                end
            end
            SAMPLE: begin
                res_valid_nxt = 1'b1;
                res_cat_nxt   = dec_cat;
                res_err_nxt   = dec_err;
                if (dec_err) begin
                    if (cnt_err != CNT_MAX) cnt_err_nxt = cnt_err + CNT_W'(1);
                end else begin
                    case (dec_cat)
                        2'd1:    if (cnt_c1 != CNT_MAX) cnt_c1_nxt = cnt_c1 + CNT_W'(1);
                        2'd2:    if (cnt_c2 != CNT_MAX) cnt_c2_nxt = cnt_c2 + CNT_W'(1);
                        default: if (cnt_c3 != CNT_MAX) cnt_c3_nxt = cnt_c3 + CNT_W'(1);
                    endcase
                end
                state_nxt = REPORT;
            end
            REPORT: begin
                if (res_valid && res_ack) begin
                    res_valid_nxt = 1'b0;
                    gate_open_nxt = !res_err;
                    stab_cnt_nxt  = '0;
                    state_nxt     = EXIT;
                end
            end
            EXIT: begin
                if (veh_present) begin
                    stab_cnt_nxt = '0;
                end else if (stab_cnt == STAB_MAX) begin
                    gate_open_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    stab_cnt_nxt = stab_cnt + STAB_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A clear wins over any increment computed above.
        if (clr_cnt) begin
            cnt_c1_nxt  = '0;
            cnt_c2_nxt  = '0;
            cnt_c3_nxt  = '0;
            cnt_err_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stab_cnt  <= '0;
            cls_p     <= '0;
            cls_e     <= '0;
            res_valid <= 1'b0;
            res_cat   <= '0;
            res_err   <= 1'b0;
            gate_open <= 1'b0;
            busy      <= 1'b0;
            cnt_c1    <= '0;
            cnt_c2    <= '0;
            cnt_c3    <= '0;
            cnt_err   <= '0;
        end else begin
            state     <= state_nxt;
            stab_cnt  <= stab_cnt_nxt;
            cls_p     <= cls_p_nxt;
            cls_e     <= cls_e_nxt;
            res_valid <= res_valid_nxt;
            res_cat   <= res_cat_nxt;
            res_err   <= res_err_nxt;
            gate_open <= gate_open_nxt;
            busy      <= (state_nxt != IDLE);
            cnt_c1    <= cnt_c1_nxt;
            cnt_c2    <= cnt_c2_nxt;
            cnt_c3    <= cnt_c3_nxt;
            cnt_err   <= cnt_err_nxt;
        end
    end

endmodule

// File: tb/tb_weigh_station_ctrl.sv
// Directed bench for weigh_station_ctrl: vector table of classifier outcomes plus
// hand-written sequences for settling restarts, aborts, exit bounce, saturation and reset.
module tb_weigh_station_ctrl;

    localparam int STABLE_CYC = 4;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             veh_present;
    logic [3:0]       peso_in;
    logic [1:0]       eixo_in;
    logic [3:0]       cls_p;
    logic [1:0]       cls_e;
    logic             cls_c1, cls_c2, cls_c3, cls_E;
    logic             res_valid;
    logic [1:0]       res_cat;
    logic             res_err;
    logic             res_ack;
    logic             gate_open;
    logic             busy;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_c1, cnt_c2, cnt_c3, cnt_err;

    weigh_station_ctrl #(.STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .veh_present(veh_present),
        .peso_in(peso_in), .eixo_in(eixo_in), .cls_p(cls_p), .cls_e(cls_e),
        .cls_c1(cls_c1), .cls_c2(cls_c2), .cls_c3(cls_c3), .cls_E(cls_E),
        .res_valid(res_valid), .res_cat(res_cat), .res_err(res_err), .res_ack(res_ack),
        .gate_open(gate_open), .busy(busy), .clr_cnt(clr_cnt),
        .cnt_c1(cnt_c1), .cnt_c2(cnt_c2), .cnt_c3(cnt_c3), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] peso;
        logic [1:0] eixo;
        logic       c1, c2, c3, e;
        int         cat;
        int         err;
    } vec_t;

    vec_t vecs [7];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_c1 = 0, exp_c2 = 0, exp_c3 = 0, exp_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cls(input logic c1, input logic c2, input logic c3, input logic e);
        cls_c1 = c1; cls_c2 = c2; cls_c3 = c3; cls_E = e;
    endtask

    task automatic model_count(input int cat, input int err);
        if (err != 0)       begin if (exp_err < CNT_MAX) exp_err++; end
        else if (cat == 1)  begin if (exp_c1 < CNT_MAX) exp_c1++; end
        else if (cat == 2)  begin if (exp_c2 < CNT_MAX) exp_c2++; end
        else if (cat == 3)  begin if (exp_c3 < CNT_MAX) exp_c3++; end
    endtask

    task automatic chk_tallies(input string tag);
        chk({tag, "_cnt_c1"},  32'(cnt_c1),  exp_c1);
        chk({tag, "_cnt_c2"},  32'(cnt_c2),  exp_c2);
        chk({tag, "_cnt_c3"},  32'(cnt_c3),  exp_c3);
        chk({tag, "_cnt_err"}, 32'(cnt_err), exp_err);
    endtask

    // Ticks until res_valid rises; returns the number of edges taken, or -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (res_valid) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: res_valid never rose within 40 cycles at %0t", $time);
        end
    endtask

    // Accept the result, release the vehicle and let the exit window elapse.
    task automatic ack_and_leave();
        res_ack = 1'b1;
        tick();
        res_ack     = 1'b0;
        veh_present = 1'b0;
        repeat (STABLE_CYC) tick();
    endtask

    task automatic quick_vehicle(input logic [3:0] p, input logic [1:0] x, input int cat, input int err);
        int cyc;
        peso_in = p; eixo_in = x; veh_present = 1'b1;
        wait_valid(cyc);
        model_count(cat, err);
        ack_and_leave();
    endtask

    task automatic full_vehicle(input int idx);
        int cyc;
        vec_t v;
        v = vecs[idx];
        set_cls(v.c1, v.c2, v.c3, v.e);
        peso_in = v.peso; eixo_in = v.eixo; veh_present = 1'b1;
        wait_valid(cyc);
        model_count(v.cat, v.err);
        chk($sformatf("v%0d_latency", idx), cyc, STABLE_CYC + 2);
        chk($sformatf("v%0d_cls_p", idx), 32'(cls_p), 32'(v.peso));
        chk($sformatf("v%0d_cls_e", idx), 32'(cls_e), 32'(v.eixo));
        chk($sformatf("v%0d_res_cat", idx), 32'(res_cat), v.cat);
        chk($sformatf("v%0d_res_err", idx), 32'(res_err), v.err);
        chk($sformatf("v%0d_busy", idx), 32'(busy), 1);
        // Result must hold while unacknowledged, even with the vehicle gone.
        veh_present = 1'b0;
        set_cls(~v.c1, ~v.c2, ~v.c3, ~v.e);
        repeat (2) tick();
        chk($sformatf("v%0d_hold_valid", idx), 32'(res_valid), 1);
        chk($sformatf("v%0d_hold_cat", idx), 32'(res_cat), v.cat);
        veh_present = 1'b1;
        res_ack = 1'b1;
        tick();
        res_ack     = 1'b0;
        veh_present = 1'b0;
        chk($sformatf("v%0d_valid_after_ack", idx), 32'(res_valid), 0);
        chk($sformatf("v%0d_gate", idx), 32'(gate_open), (v.err == 0) ? 1 : 0);
        chk_tallies($sformatf("v%0d", idx));
        repeat (STABLE_CYC - 1) tick();
        chk($sformatf("v%0d_gate_before_close", idx), 32'(gate_open), (v.err == 0) ? 1 : 0);
        tick();
        chk($sformatf("v%0d_gate_closed", idx), 32'(gate_open), 0);
        chk($sformatf("v%0d_idle", idx), 32'(busy), 0);
    endtask

    initial begin
        int cyc;
        //             peso   eixo  c1    c2    c3    E     cat err
        vecs[0] = '{4'd9,  2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2,  0};
        vecs[1] = '{4'd3,  2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1,  0};
        vecs[2] = '{4'd15, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 3,  0};
        vecs[3] = '{4'd5,  2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 0,  1};
        vecs[4] = '{4'd7,  2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 0,  1};
        vecs[5] = '{4'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1};
        vecs[6] = '{4'd12, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 0,  1};

        rst_n = 1'b0; veh_present = 1'b0; peso_in = '0; eixo_in = '0;
        res_ack = 1'b0; clr_cnt = 1'b0;
        set_cls(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_gate", 32'(gate_open), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cls_p", 32'(cls_p), 0);
        chk_tallies("rst");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) full_vehicle(i);

        // Reading changes mid-settle: stability count restarts on the new value.
        set_cls(1'b0, 1'b1, 1'b0, 1'b0);
        peso_in = 4'd9; eixo_in = 2'd2; veh_present = 1'b1;
        repeat (3) tick();
        peso_in = 4'd10;
        tick();
        chk("restart_cls_p", 32'(cls_p), 10);
        repeat (STABLE_CYC) tick();
        chk("restart_not_yet", 32'(res_valid), 0);
        tick();
        chk("restart_valid", 32'(res_valid), 1);
        chk("restart_cat", 32'(res_cat), 2);
        model_count(2, 0);
        ack_and_leave();
        chk_tallies("restart");

        // Vehicle leaves during settle: back to idle, nothing counted.
        peso_in = 4'd4; eixo_in = 2'd1; veh_present = 1'b1;
        repeat (2) tick();
        veh_present = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 0);
        repeat (STABLE_CYC + 2) tick();
        chk("abort_valid", 32'(res_valid), 0);
        chk_tallies("abort");

        // Sensor bounce while exiting restarts the zero count.
        set_cls(1'b1, 1'b0, 1'b0, 1'b0);
        peso_in = 4'd2; eixo_in = 2'd1; veh_present = 1'b1;
        wait_valid(cyc);
        model_count(1, 0);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        veh_present = 1'b0;
        repeat (2) tick();
        veh_present = 1'b1;
        tick();
        veh_present = 1'b0;
        repeat (STABLE_CYC - 1) tick();
        chk("bounce_gate_open", 32'(gate_open), 1);
        tick();
        chk("bounce_gate_closed", 32'(gate_open), 0);
        chk("bounce_idle", 32'(busy), 0);

        // Saturate the c1 tally.
        set_cls(1'b1, 1'b0, 1'b0, 1'b0);
        while (exp_c1 < CNT_MAX && n_fail < 20) quick_vehicle(4'd1, 2'd1, 1, 0);
        chk("sat_reach", 32'(cnt_c1), CNT_MAX);
        quick_vehicle(4'd1, 2'd1, 1, 0);
        chk("sat_hold", 32'(cnt_c1), CNT_MAX);

        // Clear on the SAMPLE cycle beats that cycle's increment.
        peso_in = 4'd6; eixo_in = 2'd2; veh_present = 1'b1;
        repeat (STABLE_CYC + 1) tick();
        chk("clr_pre_valid", 32'(res_valid), 0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        exp_c1 = 0; exp_c2 = 0; exp_c3 = 0; exp_err = 0;
        chk("clr_valid", 32'(res_valid), 1);
        chk("clr_cat", 32'(res_cat), 1);
        chk_tallies("clr");
        ack_and_leave();

        // Asynchronous reset while reporting.
        set_cls(1'b0, 1'b1, 1'b0, 1'b0);
        quick_vehicle(4'd8, 2'd3, 2, 0);
        chk("prereset_cnt_c2", 32'(cnt_c2), 1);
        peso_in = 4'd11; eixo_in = 2'd2; veh_present = 1'b1;
        wait_valid(cyc);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 0);
        chk("arst_gate", 32'(gate_open), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cls_p", 32'(cls_p), 0);
        exp_c1 = 0; exp_c2 = 0; exp_c3 = 0; exp_err = 0;
        chk_tallies("arst");
        veh_present = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
